// File: rtl/onchip_mem_pkg.sv
// Shared types and sizes for the two-master on-chip memory arbiter.
// Memory geometry, owner state encoding and the read-return tag layout.
package onchip_mem_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int BE_W   = DATA_W / 8;
   localparam int HOLD_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_t;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

endpackage

// File: rtl/onchip_memory_arbiter_rd_tag_pipe.sv
// Read-return tag delay line: one stage per cycle of memory read latency,
// so each tag emerges exactly when its read data appears on mem_readdata.
module rd_tag_pipe
   import onchip_mem_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic    clk,
   input  logic    flush,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);

   for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      rd_tag_t stage_q;
      rd_tag_t stage_d;

      if (gi == 0) begin : g_head
         always_comb stage_d = tag_in;
      end else begin : g_body
         always_comb stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge clk) begin
         if (flush) begin
            stage_q <= '0;
         end else begin
            stage_q <= stage_d;
         end
      end
   end

   assign tag_out = g_stage[READ_LATENCY-1].stage_q;

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter for a single-port on-chip RAM: round-robin
// with a bounded hold window, zero-latency issue, tagged read return.
module onchip_memory_arbiter #(
   parameter int ADDR_W       = onchip_mem_pkg::ADDR_W,
   parameter int DATA_W       = onchip_mem_pkg::DATA_W,
   parameter int BE_W         = onchip_mem_pkg::BE_W,
   parameter int READ_LATENCY = 1,
   parameter int MAX_HOLD     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);
   import onchip_mem_pkg::*;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   owner_t            owner_q, owner_d;
   logic              last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        req;
   logic              own_id;
   logic              gnt_valid;
   logic              gnt_id;
   logic              issue;
   logic              gnt_rd;
   rd_tag_t           tag_in;
   rd_tag_t           tag_out;

   always_comb begin
      req       = {m1_read | m1_write, m0_read | m0_write};
      own_id    = (owner_q == OWN1);
      owner_d   = IDLE;
      hold_d    = '0;
      last_d    = last_q;
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;

      // The owner keeps the port until its window runs out while the other waits.
      if (owner_q != IDLE && req[own_id] && (hold_q != HOLD_LAST || !req[~own_id])) begin
         gnt_valid = 1'b1;
         gnt_id    = own_id;
         hold_d    = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
      end else if (owner_q != IDLE && req[~own_id]) begin
         gnt_valid = 1'b1;
         gnt_id    = ~own_id;
      end else if (owner_q == IDLE && req != 2'b00) begin
         gnt_valid = 1'b1;
         gnt_id    = (req == 2'b11) ? ~last_q : req[1];
      end

      if (gnt_valid) begin
         owner_d = gnt_id ? OWN1 : OWN0;
         last_d  = gnt_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= IDLE;
         last_q  <= 1'b1;
         hold_q  <= '0;
      end else begin
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      issue          = gnt_valid & ~reset;
      mem_chipselect = issue;
      mem_address    = gnt_id ? m1_address    : m0_address;
      mem_byteenable = gnt_id ? m1_byteenable : m0_byteenable;
      mem_writedata  = gnt_id ? m1_writedata  : m0_writedata;
      mem_write      = issue & (gnt_id ? m1_write : m0_write);
      // Write has priority when a master raises read and write together.
      gnt_rd         = issue & (gnt_id ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
      m0_waitrequest = reset | (req[0] & ~(issue & ~gnt_id));
      m1_waitrequest = reset | (req[1] & ~(issue &  gnt_id));
      tag_in.valid   = gnt_rd;
      tag_in.id      = gnt_id;
   end

   rd_tag_pipe #(
      .READ_LATENCY(READ_LATENCY)
   ) u_rd_tag_pipe (
      .clk    (clk),
      .flush  (reset),
      .tag_in (tag_in),
      .tag_out(tag_out)
   );

   assign m0_readdatavalid = ~reset & tag_out.valid & ~tag_out.id;
   assign m1_readdatavalid = ~reset & tag_out.valid &  tag_out.id;
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed plus random bench for onchip_memory_arbiter against a grant-count
// reference model, a shadow memory and a queue of expected read returns.
module tb_onchip_memory_arbiter;

   localparam int AW = 15;
   localparam int DW = 16;
   localparam int BW = 2;
   localparam int RL = 1;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_address, m1_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteenable;
   logic          mem_chipselect, mem_write;
   logic [DW-1:0] mem_writedata, mem_readdata;

   always #5 clk = ~clk;

   onchip_memory_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(RL), .MAX_HOLD(MH)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
   );

   // Bus-side RAM with RL cycles of read latency.
   logic [DW-1:0] ram [0:255];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (mem_chipselect && mem_write) begin
         if (mem_byteenable[0]) ram[mem_address[7:0]][7:0]  <= mem_writedata[7:0];
         if (mem_byteenable[1]) ram[mem_address[7:0]][15:8] <= mem_writedata[15:8];
      end
      rd_pipe[0] <= ram[mem_address[7:0]];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_readdata = rd_pipe[RL-1];

   typedef struct {
      int            due;
      int            id;
      logic [DW-1:0] data;
   } pend_t;

   logic [DW-1:0] ref_mem [0:255];
   pend_t         pend[$];
   int            cur, run, last, cyc;
   int            n_assert, n_fail;
   int            rv_cnt[2];
   logic [DW-1:0] last_rd[2];
   logic          obs_wait0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic set_m(input int m, input bit rd, input bit wr, input int addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] d);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = AW'(addr); m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = AW'(addr); m1_byteenable = be; m1_writedata = d;
      end
   endtask

   // One bus cycle: inputs already driven just after the rising edge.
   task automatic cycle();
      int            g;
      bit            r0, r1, rst, g_wr, g_rd, e0, e1;
      int            g_addr;
      logic [BW-1:0] g_be;
      logic [DW-1:0] g_d, e_data;
      #3;
      rst = reset;
      r0  = m0_read | m0_write;
      r1  = m1_read | m1_write;
      g   = -1;
      if (!rst) begin
         if (r0 && r1) begin
            if (cur < 0)        g = 1 - last;
            else if (run >= MH) g = 1 - cur;
            else                g = cur;
         end else if (r0) g = 0;
         else if (r1)     g = 1;
      end
      g_wr   = (g == 1) ? m1_write : m0_write;
      g_rd   = ((g == 1) ? m1_read : m0_read) && !g_wr;
      g_addr = int'((g == 1) ? m1_address : m0_address);
      g_be   = (g == 1) ? m1_byteenable : m0_byteenable;
      g_d    = (g == 1) ? m1_writedata : m0_writedata;
      obs_wait0 = m0_waitrequest;

      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(rst || (r0 && g != 0)));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(rst || (r1 && g != 1)));
      chk("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0));
      if (g >= 0) begin
         chk("mem_write", 32'(mem_write), 32'(g_wr));
         chk("mem_address", 32'(mem_address), 32'(g_addr));
         chk("mem_byteenable", 32'(mem_byteenable), 32'(g_be));
         if (g_wr) chk("mem_writedata", 32'(mem_writedata), 32'(g_d));
      end else if (rst) begin
         chk("mem_write_rst", 32'(mem_write), 32'(0));
      end

      e0 = 0; e1 = 0; e_data = '0;
      if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
         if (pend[0].id == 0) e0 = 1; else e1 = 1;
         e_data = pend[0].data;
      end
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(e0));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(e1));
      if (e0 && m0_readdatavalid) chk("m0_readdata", 32'(m0_readdata), 32'(e_data));
      if (e1 && m1_readdatavalid) chk("m1_readdata", 32'(m1_readdata), 32'(e_data));
      if (m0_readdatavalid) begin rv_cnt[0]++; last_rd[0] = m0_readdata; end
      if (m1_readdatavalid) begin rv_cnt[1]++; last_rd[1] = m1_readdata; end
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());

      @(posedge clk);
      #1;
      if (rst) begin
         cur = -1; run = 0; last = 1;
         pend.delete();
      end else if (g >= 0) begin
         run  = (g == cur) ? run + 1 : 1;
         cur  = g;
         last = g;
         if (g_wr) begin
            if (g_be[0]) ref_mem[g_addr[7:0]][7:0]  = g_d[7:0];
            if (g_be[1]) ref_mem[g_addr[7:0]][15:8] = g_d[15:8];
         end else if (g_rd) begin
            pend.push_back('{due: cyc + RL, id: g, data: ref_mem[g_addr[7:0]]});
         end
      end else begin
         cur = -1; run = 0;
      end
      cyc++;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_counts();
      rv_cnt[0] = 0; rv_cnt[1] = 0;
   endtask

   initial begin
      int exp0;
      n_assert = 0; n_fail = 0; cyc = 0;
      cur = -1; run = 0; last = 1;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = DW'(i * 16'h0101 + 16'h3C5);
         ref_mem[i] = DW'(i * 16'h0101 + 16'h3C5);
      end
      for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
      reset = 1'b1;
      set_idle();
      set_m(0, 0, 0, 0, 2'b11, '0);
      set_m(1, 0, 0, 0, 2'b11, '0);
      @(posedge clk); #1;

      cycle();
      set_m(0, 1, 0, 16'h0005, 2'b11, '0);
      cycle();
      reset = 1'b0;
      idle_cycles(1);

      // Full write then read back on master 0.
      clear_counts();
      set_m(0, 0, 1, 16'h0010, 2'b11, 16'hBEEF); cycle();
      set_m(0, 1, 0, 16'h0010, 2'b11, 16'h0000); cycle();
      idle_cycles(RL + 1);
      chk("s1_m0_rdv_count", 32'(rv_cnt[0]), 32'd1);
      chk("s1_m1_rdv_count", 32'(rv_cnt[1]), 32'd0);
      chk("s1_readdata", 32'(last_rd[0]), 32'h0000BEEF);

      // Low-byte-only write.
      set_m(0, 0, 1, 16'h0010, 2'b01, 16'h12AB); cycle();
      set_m(0, 1, 0, 16'h0010, 2'b11, 16'h0000); cycle();
      idle_cycles(RL + 1);
      chk("byte_write_readdata", 32'(last_rd[0]), 32'h0000BEAB);

      // Continuous contention from a fresh reset.
      reset = 1'b1; idle_cycles(1); reset = 1'b0; idle_cycles(1);
      clear_counts();
      exp0 = 0;
      for (int i = 0; i < 3 * MH; i++) begin
         set_m(0, 1, 0, 16'h0040 + i, 2'b11, '0);
         set_m(1, 1, 0, 16'h0080 + i, 2'b11, '0);
         cycle();
         chk("contention_grant", 32'(obs_wait0), 32'((i / MH) % 2));
         if ((i / MH) % 2 == 0) exp0++;
      end
      idle_cycles(RL + 1);
      chk("contention_m0_count", 32'(rv_cnt[0]), 32'(exp0));
      chk("contention_m1_count", 32'(rv_cnt[1]), 32'(3 * MH - exp0));

      // Master 1 alone keeps the port for ten reads.
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         set_idle();
         set_m(1, 1, 0, 16'h0020 + i, 2'b11, '0);
         cycle();
      end
      idle_cycles(RL + 1);
      chk("m1_alone_count", 32'(rv_cnt[1]), 32'd10);

      // Reset while a read is in flight.
      set_m(0, 1, 0, 16'h0010, 2'b11, '0); cycle();
      clear_counts();
      set_idle(); reset = 1'b1; cycle(); reset = 1'b0;
      idle_cycles(RL + 3);
      chk("reset_flush_count", 32'(rv_cnt[0] + rv_cnt[1]), 32'd0);

      // Read and write together: the write is performed, no read return.
      set_m(0, 1, 1, 16'h0020, 2'b11, 16'h5A5A); cycle();
      idle_cycles(RL + 1);
      chk("rw_conflict_rdv", 32'(rv_cnt[0]), 32'd0);
      set_m(0, 1, 0, 16'h0020, 2'b11, '0); cycle();
      idle_cycles(RL + 1);
      chk("rw_conflict_data", 32'(last_rd[0]), 32'h00005A5A);

      // Random traffic from both masters.
      for (int i = 0; i < 400; i++) begin
         for (int m = 0; m < 2; m++) begin
            int op;
            op = int'($urandom_range(0, 3));
            set_m(m, op == 1, op == 2, int'($urandom_range(0, 255)),
                  BW'($urandom_range(0, 3)), DW'($urandom));
         end
         cycle();
      end
      idle_cycles(RL + 2);
      chk("random_drained", 32'(pend.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
